// File: rtl/display_scan_if.sv
// display_scan_if: enable, segment patterns in and display drive out for display_scan_ctrl
interface display_scan_if;
   logic       en;
   logic [6:0] units_seg;
   logic [6:0] decades_seg;
   logic [6:0] seg_out;
   logic [1:0] anode;
   logic       digit_sel;
   logic       frame_start;
   modport master (output en, units_seg, decades_seg, input seg_out, anode, digit_sel, frame_start);
   modport slave (input en, units_seg, decades_seg, output seg_out, anode, digit_sel, frame_start);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 2-digit common-anode 7-segment scanner with blanking and frame-coherent latching (option: LEADING_ZERO_BLANK_EN)
module display_scan_ctrl #(
   parameter int REFRESH_DIV  = 27000,
   parameter int BLANK_CYCLES = 270
) (
   input logic           clk,
   input logic           rst,
   display_scan_if.slave bus
);
   localparam int MAXC = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] SHOW_END = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif
   typedef enum logic [1:0] {S_SHOW_U = 2'd0, S_BLANK_U = 2'd1, S_SHOW_D = 2'd2, S_BLANK_D = 2'd3} state_t;
   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [6:0]    units_lat, decades_lat, units_n, decades_n, seg_n;
   logic [1:0]    anode_n;
   logic          entry, dark_d, show_last, blank_last;
   assign show_last  = cnt == SHOW_END;
   assign blank_last = BLANK_CYCLES == 0 || cnt == BLANK_END;
   // state and dwell counter; counter restarts on every state change and while disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_BLANK_D;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= (nxt != state || !bus.en) ? '0 : cnt + 1'b1;
      end
   end
   // scan order U, blank, D, blank; blank states are bypassed when BLANK_CYCLES is 0
   always_comb begin
      nxt = S_BLANK_D;
      if (bus.en)
         case (state)
            S_SHOW_U:  nxt = show_last ? (BLANK_CYCLES == 0 ? S_SHOW_D : S_BLANK_U) : S_SHOW_U;
            S_BLANK_U: nxt = blank_last ? S_SHOW_D : S_BLANK_U;
            S_SHOW_D:  nxt = show_last ? (BLANK_CYCLES == 0 ? S_SHOW_U : S_BLANK_D) : S_SHOW_D;
            default:   nxt = blank_last ? S_SHOW_U : S_BLANK_D;
         endcase
   end
   // outputs for the state being entered, so they land on the same edge as the state
   always_comb begin
      entry     = nxt == S_SHOW_U && state != S_SHOW_U;
      units_n   = entry ? bus.units_seg : units_lat;
      decades_n = entry ? bus.decades_seg : decades_lat;
      dark_d    = LZ && decades_n == 7'b0111111;
      anode_n   = nxt == S_SHOW_U ? 2'b10 : (nxt == S_SHOW_D && !dark_d) ? 2'b01 : 2'b11;
      seg_n     = anode_n == 2'b10 ? ~units_n : anode_n == 2'b01 ? ~decades_n : 7'h7F;
   end
   // both digits are captured together at frame start so a frame never mixes old and new values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         units_lat       <= '0;
         decades_lat     <= '0;
         bus.seg_out     <= 7'h7F;
         bus.anode       <= 2'b11;
         bus.digit_sel   <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         units_lat       <= units_n;
         decades_lat     <= decades_n;
         bus.seg_out     <= seg_n;
         bus.anode       <= anode_n;
         bus.digit_sel   <= nxt[1];
         bus.frame_start <= entry;
      end
   end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized scan check of a blanking and a non-blanking instance against a frame-position model
module tb_display_scan_ctrl;
   localparam int R = 4;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [6:0] units, decades;
   int         errors = 0;
   int         checks = 0;
   display_scan_if b0 ();
   display_scan_if b1 ();
   assign b0.en = en;
   assign b0.units_seg = units;
   assign b0.decades_seg = decades;
   assign b1.en = en;
   assign b1.units_seg = units;
   assign b1.decades_seg = decades;
   display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   always #5 clk = ~clk;
   logic [1:0] an[2];
   logic [6:0] sg[2];
   logic       fs[2], ds[2];
   assign an[0] = b0.anode;
   assign an[1] = b1.anode;
   assign sg[0] = b0.seg_out;
   assign sg[1] = b1.seg_out;
   assign fs[0] = b0.frame_start;
   assign fs[1] = b1.frame_start;
   assign ds[0] = b0.digit_sel;
   assign ds[1] = b1.digit_sel;
   function automatic int blk(input int i);
      return i == 0 ? 2 : 0;
   endfunction
   function automatic int startup(input int i);
      return blk(i) == 0 ? 1 : blk(i);
   endfunction
   function automatic int frame(input int i);
      return 2 * (R + blk(i));
   endfunction
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: p = cycles into the frame schedule, negative while in the initial blank
   int         p[2] = '{-2, -1};
   logic [6:0] lu[2] = '{7'h00, 7'h00};
   logic [6:0] ld[2] = '{7'h00, 7'h00};
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            p[i]  <= -startup(i);
            lu[i] <= 7'h00;
            ld[i] <= 7'h00;
         end else if (!en) begin
            p[i] <= -startup(i);
         end else begin
            p[i] <= p[i] + 1;
            if (p[i] + 1 >= 0 && (p[i] + 1) % frame(i) == 0) begin
               lu[i] <= units;
               ld[i] <= decades;
            end
         end
      end
   end
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int         q;
         logic       eu, ed;
         logic [1:0] ea;
         logic [6:0] es;
         q  = p[i] % frame(i);
         eu = p[i] >= 0 && q < R;
         ed = p[i] >= 0 && q >= R + blk(i) && q < 2 * R + blk(i);
         ea = eu ? 2'b10 : (ed && !(LZ && ld[i] == 7'b0111111)) ? 2'b01 : 2'b11;
         es = ea == 2'b10 ? ~lu[i] : ea == 2'b01 ? ~ld[i] : 7'h7F;
         chk($sformatf("anode%0d", i), {6'd0, an[i]}, {6'd0, ea});
         chk($sformatf("seg%0d", i), {1'b0, sg[i]}, {1'b0, es});
         chk($sformatf("frame_start%0d", i), {7'd0, fs[i]}, {7'd0, p[i] >= 0 && q == 0});
         if (eu || ed) chk($sformatf("digit_sel%0d", i), {7'd0, ds[i]}, {7'd0, ed});
      end
   end
   initial begin
      int   off;
      logic found;
      rst = 1'b1;
      en = 1'b1;
      units = 7'b0000110;
      decades = 7'b0111111;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         case (k)
            1: begin
               chk("lit_a0_k1", {6'd0, an[0]}, 8'h03);
               chk("lit_a1_k1", {6'd0, an[1]}, 8'h02);
               chk("lit_s1_k1", {1'b0, sg[1]}, 8'b01111001);
               chk("lit_f1_k1", {7'd0, fs[1]}, 8'h01);
            end
            2: begin
               chk("lit_a0_k2", {6'd0, an[0]}, 8'h02);
               chk("lit_s0_k2", {1'b0, sg[0]}, 8'b01111001);
               chk("lit_f0_k2", {7'd0, fs[0]}, 8'h01);
            end
            3: chk("lit_f0_k3", {7'd0, fs[0]}, 8'h00);
            6: chk("lit_a0_k6", {6'd0, an[0]}, 8'h03);
            8: begin
               chk("lit_a0_k8", {6'd0, an[0]}, LZ ? 8'h03 : 8'h01);
               chk("lit_s0_k8", {1'b0, sg[0]}, LZ ? 8'h7F : 8'b01000000);
            end
            9: units = 7'b1011011;
            10: chk("lit_s1_k10", {1'b0, sg[1]}, 8'b01111001);
            14: begin
               chk("lit_s0_k14", {1'b0, sg[0]}, 8'b00100100);
               chk("lit_f0_k14", {7'd0, fs[0]}, 8'h01);
            end
            16: begin
               chk("lit_a0_k16", {6'd0, an[0]}, 8'h02);
               en = 1'b0;
            end
            17: begin
               chk("lit_a0_k17", {6'd0, an[0]}, 8'h03);
               chk("lit_s0_k17", {1'b0, sg[0]}, 8'h7F);
               chk("lit_f0_k17", {7'd0, fs[0]}, 8'h00);
               chk("lit_a1_k17", {6'd0, an[1]}, 8'h03);
               en = 1'b1;
            end
            18: begin
               chk("lit_a0_k18", {6'd0, an[0]}, 8'h03);
               chk("lit_a1_k18", {6'd0, an[1]}, 8'h02);
               chk("lit_s1_k18", {1'b0, sg[1]}, 8'b00100100);
            end
            19: begin
               chk("lit_a0_k19", {6'd0, an[0]}, 8'h02);
               chk("lit_s0_k19", {1'b0, sg[0]}, 8'b00100100);
               chk("lit_f0_k19", {7'd0, fs[0]}, 8'h01);
            end
            default: ;
         endcase
      end
      off = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (off > 0) off--;
         else if ($urandom_range(39) == 0) off = $urandom_range(6, 1);
         en = off == 0;
         if ($urandom_range(7) == 0) units = 7'($urandom);
         if ($urandom_range(7) == 0) decades = $urandom_range(1) ? 7'b0111111 : 7'($urandom);
      end
      en = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         found = an[0] == 2'b01 || (LZ && an[0] == 2'b11 && ds[0] && p[0] >= 0 && p[0] % frame(0) == R + 2);
      end
      chk("wait_show_d", {7'd0, found}, 8'h01);
      #2 rst = 1'b1;
      #1;
      chk("async_anode", {6'd0, an[0]}, 8'h03);
      chk("async_seg", {1'b0, sg[0]}, 8'h7F);
      chk("async_fs", {7'd0, fs[0]}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
